ps2_dev_tx: RTL and testbench
=============================

// Module: ps2_dev_tx
// PURPOSE
//  Parametrised PS/2 device-side transmitter; next-generation keyboard model for the SoC sim/FPGA env.
//  Bytes (scancodes) pushed via valid/ready into an internal FIFO.
//  Each byte is serialised as an 11-bit PS/2 frame on ps2_clk/ps2_dat, with a programmable inter-frame gap.
//  ps2_clk toggles only during a frame; line is idle-high otherwise. Feeds the PS/2 host controller.
// PARAMETERS
//  CLK_DIV     2500  system clocks per PS/2 bit (25 MHz -> 10 kHz); even, >=4
//  FIFO_DEPTH  8     scancode FIFO entries; power of 2, >=2
//  GAP_BITS    2     idle bit-times inserted after each stop bit; 0 allowed
// PORTS
//  clock       in   1   system clock
//  resetn      in   1   asynchronous, active-low reset
//  in_valid    in   1   byte offered
//  in_data     in   8   scancode byte
//  in_ready    out  1   FIFO can accept (= !full)
//  fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied entries
//  busy        out  1   1 while not IDLE, or FIFO/pending non-empty
//  ps2_clk     out  1   PS/2 clock to host
//  ps2_dat     out  1   PS/2 data to host
//  ps2_clk_in  in   1   host view of clock wire (0 = host inhibit); present only with PS2_INHIBIT_EN
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): FIFO/pending cleared; state IDLE.
//   Outputs: ps2_clk=1, ps2_dat=1, in_ready=1, fifo_level=0, busy=0.
//  FIFO: push when in_valid&in_ready. in_ready=0 when full, even if a pop happens that cycle.
//   Push and pop in the same cycle: level unchanged. No pop when empty. Pointers wrap mod FIFO_DEPTH.
//  Frame bits, in order: start 0; d[0..7] LSB first; odd parity (~^d); stop 1.
//  Bit timing: phase counter 0..CLK_DIV-1 per bit.
//   ps2_clk=1 for phase < CLK_DIV/2, else 0.
//   ps2_dat changes only at phase 0 (clk high); host samples on the ps2_clk falling edge.
//  FSM:
//   IDLE:  if pending or FIFO non-empty (and not inhibited): load shift reg (pending first, else pop); -> FRAME.
//          Next cycle: phase 0 of start bit (ps2_dat=0, ps2_clk=1).
//   FRAME: 11 bits x CLK_DIV cycles. After phase CLK_DIV-1 of stop bit: -> GAP (GAP_BITS>0) or IDLE.
//   GAP:   GAP_BITS*CLK_DIV cycles, clk=1 dat=1; -> IDLE.
//  Start-of-frame latency: 1 cycle after byte visible at FIFO head. Back-to-back frame period: (11+GAP_BITS)*CLK_DIV.
//  All outputs registered; no combinational path from in_* to ps2_*.
// CONFIGURATION
//  PS2_INHIBIT_EN defined: ps2_clk_in is 2-flop synchronised.
//   Inhibit = sync value 0 while own ps2_clk output is 1.
//   IDLE: no frame starts while inhibited.
//   FRAME, before stop-bit phase 0: abort. Drive clk=1 dat=1; byte kept in pending reg; -> GAP (full length),
//    then IDLE; the same byte is retransmitted from start bit once the inhibit clears.
//   FRAME, stop bit: no abort. GAP: counter held while inhibited.
//  PS2_INHIBIT_EN undefined: port ps2_clk_in absent; inhibit never asserted; pending reg unused.
// TESTING (CLK_DIV=4, FIFO_DEPTH=4, GAP_BITS=2 unless noted)
//  Reset, idle 100 cycles -> ps2_clk=1, ps2_dat=1 constant; in_ready=1; busy=0; level=0.
//  Push 0x1C -> 11 clk falls in 44 cycles; sampled bits 0,0,0,1,1,1,0,0,0,0,1.
//   Then 8 idle-high cycles; busy=0.
//  Push 0xF0, 0x00, 0xFF back-to-back -> parity bits 1,1,1; frame starts 52 cycles apart; order preserved.
//  Push 6 bytes with frame in progress -> in_ready=0 after 5th accepted (4 FIFO + 1 in flight).
//   6th held until a pop; all 6 sent in order.
//  Assert resetn=0 at bit 5 of a frame -> next cycle ps2_clk=1, ps2_dat=1, level=0; no further clk edges.
//  PS2_INHIBIT_EN: ps2_clk_in=0 during d[3] of 0x5A for 20 cycles -> abort, lines high.
//   After release + sync + 8-cycle gap: full frame of 0x5A resent (parity 1).

Source files
------------

// File: rtl/ps2_dev_tx.sv
// rtl/ps2_dev_tx.sv - PS/2 device-side transmitter with scancode FIFO and inter-frame gap
// Optional host-inhibit handling (ps2_clk_in) is enabled by defining PS2_INHIBIT_EN.
module ps2_dev_tx #(
    parameter int CLK_DIV    = 2500,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_BITS   = 2
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            in_valid,
    input  logic [7:0]                      in_data,
    output logic                            in_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            busy,
    output logic                            ps2_clk,
    output logic                            ps2_dat
`ifdef PS2_INHIBIT_EN
    ,
    input  logic                            ps2_clk_in
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(CLK_DIV);
    localparam int GW = $clog2(GAP_BITS + 2);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV / 2);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [3:0]    STOP_BIT = 4'd10;

    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    state_t          state;
    logic [PW-1:0]   phase;
    logic [PW-1:0]   phase_nxt;
    logic [3:0]      bit_idx;
    logic [GW-1:0]   gap_cnt;
    logic [10:0]     frame;
    logic            pending_valid;
    logic [7:0]      pending_data;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;

    logic            inhibit;
    logic            push;
    logic            pop;
    logic            have_data;
    logic            boundary;
    logic            load;
    logic [7:0]      load_data;

`ifdef PS2_INHIBIT_EN
    logic [1:0] clk_sync;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
        end
    end

    // Host pulling the wire low only counts while we are releasing it high.
    assign inhibit = !clk_sync[1] && ps2_clk;
`else
    assign inhibit = 1'b0;
`endif

    assign in_ready   = (level != LVL_FULL);
    assign fifo_level = level;
    assign push       = in_valid && in_ready;
    assign have_data  = pending_valid || (level != '0);
    assign busy       = (state != IDLE) || have_data;
    assign phase_nxt  = phase + PW'(1);

    // A new frame may start from IDLE or directly out of the last gap cycle,
    // which keeps the back-to-back period at exactly (11+GAP_BITS) bit-times.
    always_comb begin
        boundary = 1'b0;
        case (state)
            IDLE:    boundary = 1'b1;
            FRAME:   boundary = (GAP_BITS == 0) && (phase == PH_LAST) && (bit_idx == STOP_BIT);
            GAP:     boundary = (phase == PH_LAST) && (gap_cnt == GAP_LAST);
            default: boundary = 1'b0;
        endcase
        load      = boundary && have_data && !inhibit;
        pop       = load && !pending_valid;
        load_data = pending_valid ? pending_data : mem[rd_ptr];
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            phase         <= '0;
            bit_idx       <= '0;
            gap_cnt       <= '0;
            frame         <= '1;
            pending_valid <= 1'b0;
            pending_data  <= '0;
            ps2_clk       <= 1'b1;
            ps2_dat       <= 1'b1;
        end else if (load) begin
            state         <= FRAME;
            phase         <= '0;
            bit_idx       <= '0;
            frame         <= {1'b1, ~^load_data, load_data, 1'b0};
            pending_valid <= 1'b0;
            ps2_clk       <= 1'b1;
            ps2_dat       <= 1'b0;
        end else begin
            case (state)
                FRAME: begin
                    if (inhibit && (bit_idx != STOP_BIT)) begin
                        // Abort: keep the byte so it is resent whole after the gap.
                        state         <= (GAP_BITS > 0) ? GAP : IDLE;
                        phase         <= '0;
                        gap_cnt       <= '0;
                        pending_valid <= 1'b1;
                        pending_data  <= frame[8:1];
                        ps2_clk       <= 1'b1;
                        ps2_dat       <= 1'b1;
                    end else if (phase != PH_LAST) begin
                        phase   <= phase_nxt;
                        ps2_clk <= (phase_nxt < PH_HALF);
                    end else if (bit_idx != STOP_BIT) begin
                        phase   <= '0;
                        bit_idx <= bit_idx + 4'd1;
                        ps2_clk <= 1'b1;
                        ps2_dat <= frame[bit_idx + 4'd1];
                    end else begin
                        state   <= (GAP_BITS > 0) ? GAP : IDLE;
                        phase   <= '0;
                        gap_cnt <= '0;
                        ps2_clk <= 1'b1;
                        ps2_dat <= 1'b1;
                    end
                end
                GAP: begin
                    if (!inhibit) begin
                        if (phase != PH_LAST) begin
                            phase <= phase_nxt;
                        end else if (gap_cnt != GAP_LAST) begin
                            phase   <= '0;
                            gap_cnt <= gap_cnt + GW'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    ps2_clk <= 1'b1;
                    ps2_dat <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// tb/tb_ps2_dev_tx.sv - directed self-checking bench for ps2_dev_tx (CLK_DIV=4, FIFO_DEPTH=4, GAP_BITS=2)
module tb_ps2_dev_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP_BITS   = 2;

    logic       clock;
    logic       resetn;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [2:0] fifo_level;
    logic       busy;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       host_clk = 1'b1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int   fall_cyc [$];
    logic fall_bit [$];
    logic prev_clk = 1'b1;

    ps2_dev_tx #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH),
        .GAP_BITS  (GAP_BITS)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .fifo_level(fifo_level),
        .busy      (busy),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat)
`ifdef PS2_INHIBIT_EN
        ,
        .ps2_clk_in(host_clk)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Host-side view: record the data bit at every ps2_clk falling edge.
    always @(negedge clock) begin
        if (prev_clk && !ps2_clk) begin
            fall_cyc.push_back(cyc);
            fall_bit.push_back(ps2_dat);
        end
        prev_clk <= ps2_clk;
    end

    task automatic push_byte(input logic [7:0] d, output int c0);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clock); #1;
        c0       = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_falls(input int n, input int budget, output bit ok);
        int t = 0;
        while (fall_cyc.size() < n && t < budget) begin
            @(posedge clock); #1;
            t++;
        end
        ok = (fall_cyc.size() >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int t = 0;
        while (busy !== 1'b0 && t < budget) begin
            @(posedge clock); #1;
            t++;
        end
        ok = (busy === 1'b0);
    endtask

    function automatic logic [10:0] got_frame(input int base);
        logic [10:0] g;
        for (int i = 0; i < 11; i++) g[i] = fall_bit[base + i];
        return g;
    endfunction

    task automatic test_reset;
        int bad_lines = 0, bad_ready = 0, bad_busy = 0, bad_level = 0;
        resetn = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({ps2_clk, ps2_dat, in_ready, busy, fifo_level} !== 7'b1110_000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", {ps2_clk, ps2_dat, in_ready, busy, fifo_level}, 7'b1110_000);
        end
        resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1) bad_lines++;
            if (in_ready !== 1'b1) bad_ready++;
            if (busy !== 1'b0) bad_busy++;
            if (fifo_level !== 3'd0) bad_level++;
        end
        checks++; if (bad_lines != 0) begin failures++; $display("FAIL idle_lines bad_cycles=%0d exp=0", bad_lines); end
        checks++; if (bad_ready != 0) begin failures++; $display("FAIL idle_in_ready bad_cycles=%0d exp=0", bad_ready); end
        checks++; if (bad_busy != 0)  begin failures++; $display("FAIL idle_busy bad_cycles=%0d exp=0", bad_busy); end
        checks++; if (bad_level != 0) begin failures++; $display("FAIL idle_level bad_cycles=%0d exp=0", bad_level); end
    endtask

    task automatic test_single;
        int base = fall_cyc.size();
        int c0, bad_gap = 0;
        bit ok;
        push_byte(8'h1C, c0);
        wait_falls(base + 11, 100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_frame timeout falls=%0d exp=11", fall_cyc.size() - base);
        end else begin
            if (got_frame(base) !== 11'b1_0_00011100_0) begin
                failures++;
                $display("FAIL single_bits got=%b exp=%b", got_frame(base), 11'b1_0_00011100_0);
            end
            checks++;
            if (fall_cyc[base] - c0 != 3) begin
                failures++;
                $display("FAIL single_latency got=%0d exp=3", fall_cyc[base] - c0);
            end
            checks++;
            if (fall_cyc[base + 10] - fall_cyc[base] != 40) begin
                failures++;
                $display("FAIL single_span got=%0d exp=40", fall_cyc[base + 10] - fall_cyc[base]);
            end
        end
        while (cyc < c0 + 44) begin @(posedge clock); #1; end
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1 || busy !== 1'b1) bad_gap++;
        end
        checks++;
        if (bad_gap != 0) begin failures++; $display("FAIL single_gap bad_cycles=%0d exp=0", bad_gap); end
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b0 || fall_cyc.size() != base + 11) begin
            failures++;
            $display("FAIL single_done busy=%b falls=%0d exp busy=0 falls=11", busy, fall_cyc.size() - base);
        end
    endtask

    task automatic test_back_to_back;
        int base = fall_cyc.size();
        int c0;
        bit ok;
        logic [10:0] exp_f [3];
        exp_f[0] = 11'b1_1_11110000_0;
        exp_f[1] = 11'b1_1_00000000_0;
        exp_f[2] = 11'b1_1_11111111_0;
        push_byte(8'hF0, c0);
        push_byte(8'h00, c0);
        push_byte(8'hFF, c0);
        wait_falls(base + 33, 250, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_timeout falls=%0d exp=33", fall_cyc.size() - base);
        end else begin
            for (int f = 0; f < 3; f++) begin
                checks++;
                if (got_frame(base + 11 * f) !== exp_f[f]) begin
                    failures++;
                    $display("FAIL b2b_bits frame=%0d got=%b exp=%b", f, got_frame(base + 11 * f), exp_f[f]);
                end
            end
            for (int f = 1; f < 3; f++) begin
                checks++;
                if (fall_cyc[base + 11 * f] - fall_cyc[base + 11 * (f - 1)] != 52) begin
                    failures++;
                    $display("FAIL b2b_period frame=%0d got=%0d exp=52", f,
                             fall_cyc[base + 11 * f] - fall_cyc[base + 11 * (f - 1)]);
                end
            end
        end
        wait_idle(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_fifo_full;
        int base = fall_cyc.size();
        int k = 0, stall = 0, t = 0;
        bit ok, acc;
        logic [7:0] bytes [6];
        logic       par   [6];
        bytes[0] = 8'h11; par[0] = 1'b1;
        bytes[1] = 8'h07; par[1] = 1'b0;
        bytes[2] = 8'h33; par[2] = 1'b1;
        bytes[3] = 8'h80; par[3] = 1'b0;
        bytes[4] = 8'h55; par[4] = 1'b1;
        bytes[5] = 8'hE9; par[5] = 1'b0;
        while (k < 6 && t < 400) begin
            in_valid = 1'b1;
            in_data  = bytes[k];
            acc      = in_ready;
            @(posedge clock); #1;
            t++;
            if (acc) begin
                k++;
                if (k == 5) begin
                    checks++;
                    if (in_ready !== 1'b0 || fifo_level !== 3'd4) begin
                        failures++;
                        $display("FAIL full_after5 in_ready=%b level=%0d exp in_ready=0 level=4", in_ready, fifo_level);
                    end
                end
            end else begin
                stall++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (k != 6 || stall != 49) begin
            failures++;
            $display("FAIL full_stall accepted=%0d stall=%0d exp accepted=6 stall=49", k, stall);
        end
        wait_falls(base + 66, 500, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL full_timeout falls=%0d exp=66", fall_cyc.size() - base);
        end else begin
            for (int f = 0; f < 6; f++) begin
                checks++;
                if (got_frame(base + 11 * f) !== {1'b1, par[f], bytes[f], 1'b0}) begin
                    failures++;
                    $display("FAIL full_order frame=%0d got=%b exp=%b", f, got_frame(base + 11 * f),
                             {1'b1, par[f], bytes[f], 1'b0});
                end
            end
        end
        wait_idle(100, ok);
    endtask

    task automatic test_reset_mid_frame;
        int base = fall_cyc.size();
        int c0, n0;
        bit ok;
        push_byte(8'hAA, c0);
        push_byte(8'h55, c0);
        wait_falls(base + 6, 100, ok);
        resetn = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (!ok || {ps2_clk, ps2_dat, busy, fifo_level} !== 6'b110_000) begin
            failures++;
            $display("FAIL midreset_outputs reached=%b got=%b exp=%b", ok, {ps2_clk, ps2_dat, busy, fifo_level}, 6'b110_000);
        end
        repeat (2) begin @(posedge clock); #1; end
        resetn = 1'b1;
        n0 = fall_cyc.size();
        repeat (60) begin @(posedge clock); #1; end
        checks++;
        if (fall_cyc.size() != n0) begin
            failures++;
            $display("FAIL midreset_no_edges got=%0d exp=0", fall_cyc.size() - n0);
        end
        checks++;
        if ({ps2_clk, ps2_dat, busy, in_ready} !== 4'b1101) begin
            failures++;
            $display("FAIL midreset_idle got=%b exp=%b", {ps2_clk, ps2_dat, busy, in_ready}, 4'b1101);
        end
    endtask

`ifdef PS2_INHIBIT_EN
    task automatic test_inhibit;
        int base = fall_cyc.size();
        int c0, rel, partial;
        bit ok;
        push_byte(8'h5A, c0);
        wait_falls(base + 4, 100, ok);
        @(posedge clock); #1;
        host_clk = 1'b0;
        repeat (19) begin @(posedge clock); #1; end
        checks++;
        if ({ps2_clk, ps2_dat, busy} !== 3'b111) begin
            failures++;
            $display("FAIL inhibit_lines got=%b exp=111", {ps2_clk, ps2_dat, busy});
        end
        @(posedge clock); #1;
        host_clk = 1'b0;
        partial  = fall_cyc.size() - base;
        host_clk = 1'b1;
        rel      = cyc;
        checks++;
        if (!ok || partial != 5) begin
            failures++;
            $display("FAIL inhibit_abort partial_falls=%0d exp=5", partial);
        end
        wait_falls(base + partial + 11, 200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL inhibit_resend timeout falls=%0d exp=%0d", fall_cyc.size() - base, partial + 11);
        end else begin
            if (got_frame(base + partial) !== 11'b1_1_01011010_0) begin
                failures++;
                $display("FAIL inhibit_resend_bits got=%b exp=%b", got_frame(base + partial), 11'b1_1_01011010_0);
            end
            checks++;
            if (fall_cyc[base + partial] - rel != 12) begin
                failures++;
                $display("FAIL inhibit_resend_delay got=%0d exp=12", fall_cyc[base + partial] - rel);
            end
        end
        wait_idle(100, ok);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
`ifdef PS2_INHIBIT_EN
        test_inhibit();
`endif
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
